fetch_sequencer: RTL and testbench

- Front-end stage directly upstream of the instruction decoder.
- Owns the program counter, instruction register and return-address register.
- Fetches 8-bit instructions from instruction memory over a req/ack handshake and presents them as `opcode` to the decoder.
- Consumes the decoder's `branch_enable` and `halt` to compute the next PC: sequential, BRANCH, RET or halt.

---
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end stage feeding the instruction decoder.
// Owns pc, ir and the single-level return-address link.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   imem_addr      fetch address (always equal to pc)
//   imem_req       fetch request, high in FETCH only
//   imem_rdata     instruction byte, valid with imem_ack
//   imem_ack       one-cycle memory response strobe
//   opcode         instruction register, routed to the decoder
//   ir_valid       one-cycle strobe while the opcode executes
//   branch_enable  decoder output for the current opcode
//   halt           decoder output for the current opcode
//   pc             current program counter
//   halted         high once a halt has executed, until reset
//   retired_count  saturating count of executed instructions
module fetch_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_req,
    input  logic [7:0]            imem_rdata,
    input  logic                  imem_ack,
    output logic [7:0]            opcode,
    output logic                  ir_valid,
    input  logic                  branch_enable,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  retired_count
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALTED
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic [7:0]            ir;
    logic [CNT_WIDTH-1:0]  cnt;

    logic                  is_branch;
    logic                  is_ret;
    logic [ADDR_WIDTH-1:0] branch_target;

    // Only the high nibble selects the control-flow kind; the
    // decoder's branch_enable must also be asserted.
    assign is_branch     = branch_enable && (ir[7:4] == 4'hC);
    assign is_ret        = branch_enable && (ir[7:4] == 4'hB);
    assign branch_target = {{(ADDR_WIDTH-4){1'b0}}, ir[3:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc_q     <= '0;
            ret_addr <= '0;
            ir       <= 8'h00;
            cnt      <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (halt) begin
                        state <= S_HALTED;
                    end else begin
                        state <= S_FETCH;
                        if (is_branch) begin
                            ret_addr <= pc_q + 1'b1;
                            pc_q     <= branch_target;
                        end else if (is_ret) begin
                            pc_q <= ret_addr;
                        end else begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_req      = (state == S_FETCH);
    assign ir_valid      = (state == S_EXECUTE);
    assign halted        = (state == S_HALTED);
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign opcode        = ir;
    assign retired_count = cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random programs, random wait states,
// stray acks and resets checked against an instruction-level model.
module tb_fetch_sequencer;

    localparam int AW = 4;
    localparam int CW = 6;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int N_EP = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] imem_addr;
    logic          imem_req;
    logic [7:0]    imem_rdata;
    logic          imem_ack;
    logic [7:0]    opcode;
    logic          ir_valid;
    logic          branch_enable;
    logic          halt;
    logic [AW-1:0] pc;
    logic          halted;
    logic [CW-1:0] retired_count;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .opcode       (opcode),
        .ir_valid     (ir_valid),
        .branch_enable(branch_enable),
        .halt         (halt),
        .pc           (pc),
        .halted       (halted),
        .retired_count(retired_count)
    );

    // Decoder stand-in: 0xCE is both a branch and a halt.
    assign halt          = (opcode == 8'hFF) || (opcode == 8'hCE);
    assign branch_enable = (opcode[7:4] == 4'hA) ||
                           (opcode[7:4] == 4'hB) ||
                           (opcode[7:4] == 4'hC);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    logic [7:0] mem [16];

    function automatic logic [7:0] rand_op(input bit halt_ok);
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 19);
        if (r < 8) begin
            b = 8'($urandom_range(0, 8'h9F));
        end else if (r < 12) begin
            b = {4'hC, 4'($urandom_range(0, 15))};
            if (b == 8'hCE && !halt_ok) b = 8'hCD;
        end else if (r < 15) begin
            b = {4'hB, 4'($urandom_range(0, 15))};
        end else if (r < 17) begin
            b = {4'hA, 4'($urandom_range(0, 15))};
        end else if (r == 17 && halt_ok) begin
            b = 8'hFF;
        end else begin
            b = 8'h01;
        end
        return b;
    endfunction

    task automatic load_prog(input int ep);
        for (int i = 0; i < 16; i++) mem[i] = 8'h01;
        case (ep)
            0: begin
                mem[0] = 8'h01; mem[1] = 8'h12;
                mem[2] = 8'h23; mem[3] = 8'hFF;
            end
            1: begin
                mem[0] = 8'hC5; mem[5] = 8'h10;
                mem[6] = 8'hB0; mem[1] = 8'hFF;
            end
            2: ;
            3: begin
                mem[0] = 8'h01; mem[1] = 8'hFF;
            end
            default: begin
                for (int i = 0; i < 16; i++)
                    mem[i] = rand_op(ep % 2 == 1);
            end
        endcase
    endtask

    // Instruction-level reference state
    int         m_pc;
    int         m_ret;
    int         m_cnt;
    bit         m_halted;
    logic [7:0] m_ir;
    int         age;
    bit         ack_drove;
    int         wait_left;
    int         halt_cycles;
    int         limit;
    bit         zero_wait;
    bit         exp_req;
    bit         exp_valid;

    task automatic model_reset();
        m_pc        = 0;
        m_ret       = 0;
        m_cnt       = 0;
        m_halted    = 1'b0;
        m_ir        = 8'h00;
        age         = 3;
        ack_drove   = 1'b0;
        halt_cycles = 0;
        wait_left   = 0;
    endtask

    task automatic model_execute();
        logic [3:0] hi;
        hi = m_ir[7:4];
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_ir == 8'hFF || m_ir == 8'hCE) begin
            m_halted = 1'b1;
        end else if (hi == 4'hC) begin
            m_ret = (m_pc + 1) % 16;
            m_pc  = int'(m_ir[3:0]);
        end else if (hi == 4'hB) begin
            m_pc = m_ret;
        end else begin
            m_pc = (m_pc + 1) % 16;
        end
    endtask

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        for (int ep = 0; ep < N_EP; ep++) begin
            load_prog(ep);
            zero_wait = (ep < 2);
            limit = (ep == 2) ? 450 : int'($urandom_range(30, 300));
            rst      = 1'b1;
            imem_ack = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            model_reset();
            check("rst_pc", 32'(pc), 32'(0));
            check("rst_req", 32'(imem_req), 32'(1));
            check("rst_halted", 32'(halted), 32'(0));
            check("rst_valid", 32'(ir_valid), 32'(0));
            check("rst_cnt", 32'(retired_count), 32'(0));
            check("rst_opcode", 32'(opcode), 32'(0));
            for (int cyc = 0; cyc < limit; cyc++) begin
                exp_req   = !m_halted && age >= 3;
                ack_drove = 1'b0;
                if (exp_req) begin
                    if (wait_left > 0) begin
                        imem_ack = 1'b0;
                        wait_left--;
                    end else begin
                        imem_ack   = 1'b1;
                        imem_rdata = mem[imem_addr];
                        ack_drove  = 1'b1;
                        m_ir       = mem[m_pc];
                        if (!zero_wait && $urandom_range(0, 1) == 1)
                            wait_left = $urandom_range(1, 4);
                    end
                end else begin
                    imem_ack   = ($urandom_range(0, 2) == 0);
                    imem_rdata = 8'($urandom_range(0, 255));
                end
                @(posedge clk);
                #1;
                imem_ack = 1'b0;
                if (ack_drove) age = 1;
                else if (age < 3) age++;
                exp_req   = !m_halted && age >= 3;
                exp_valid = !m_halted && age == 2;
                check("pc", 32'(pc), 32'(m_pc));
                check("imem_addr", 32'(imem_addr), 32'(m_pc));
                check("imem_req", 32'(imem_req), 32'(exp_req));
                check("ir_valid", 32'(ir_valid), 32'(exp_valid));
                check("halted", 32'(halted), 32'(m_halted));
                check("opcode", 32'(opcode), 32'(m_ir));
                check("retired", 32'(retired_count), 32'(m_cnt));
                if (exp_valid) model_execute();
                if (m_halted) begin
                    halt_cycles++;
                    if (halt_cycles > 20) break;
                end
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
